mem_access_unit: RTL and testbench

//  MEM-stage data-bus initiator. Takes the EX/MEM payload, issues at most one 64-bit dbus

---
 rtl/mem_access_unit_pkg.sv | 53 +++++
 rtl/mem_data_align.sv | 37 +++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage data-bus initiator: pipeline payloads, dbus
// request/response records and the access-size encoding.
package mem_access_unit_pkg;
  localparam int BYTES = 8;
  localparam int OFF_W = 3;

  typedef enum logic [1:0] {MSZ_B, MSZ_H, MSZ_W, MSZ_D} msize_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} mem_state_t;

  typedef struct packed {
    logic        valid;
    logic        mem_rd;
    logic        mem_wr;
    msize_t      msize;
    logic        msign;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        reg_wr;
    logic [4:0]  rd;
  } execute_data_t;

  // rdata carries the loaded value; for non-loads it carries addr (the ALU result)
  typedef struct packed {
    logic        valid;
    logic [63:0] rdata;
    logic        misalign;
    logic        reg_wr;
    logic [4:0]  rd;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic logic [BYTES-1:0] size_mask(msize_t s);
    case (s)
      MSZ_B:   return 8'h01;
      MSZ_H:   return 8'h03;
      MSZ_W:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction
endpackage

// File: rtl/mem_data_align.sv
// Byte-lane steering for dbus: store strobe/shift and load shift with
// sign/zero extension. Purely combinational.
module mem_data_align
  import mem_access_unit_pkg::*;
(
  input  msize_t                msize,
  input  logic                  msign,
  input  logic [OFF_W-1:0]      off,
  input  logic [63:0]           wdata,
  input  logic [63:0]           line,
  output logic [BYTES-1:0]      strobe,
  output logic [63:0]           wdata_al,
  output logic [63:0]           rdata
);
  logic [BYTES-1:0]      mask;
  logic [BYTES-1:0][7:0] raw;
  logic                  fill;

  assign mask     = size_mask(msize);
  assign strobe   = mask << off;
  assign wdata_al = wdata << {off, 3'b000};
  assign raw      = line >> {off, 3'b000};

  always_comb begin
    fill = 1'b0;
    case (msize)
      MSZ_B:   fill = msign & raw[0][7];
      MSZ_H:   fill = msign & raw[1][7];
      MSZ_W:   fill = msign & raw[3][7];
      default: fill = 1'b0;
    endcase
  end

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    assign rdata[8*i +: 8] = mask[i] ? raw[i] : {8{fill}};
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage dbus initiator: issues one request per memory instruction, holds
// the pipeline until completion, drains flushed transactions to completion.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  execute_data_t     dataE,
  output memory_data_t      dataM,
  output logic              stallM,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data
);
  mem_state_t     state, state_nxt;
  execute_data_t  lat, cur;
  dbus_req_t      req;
  dbus_resp_t     resp;
  logic [OFF_W-1:0] amask;
  logic           misal, mem_op, issue, req_on, done;
  logic [7:0]     strobe;
  logic [63:0]    wdata_al, ld_data;

  assign resp   = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};
  assign amask  = 3'((4'd1 << dataE.msize) - 4'd1);
  assign misal  = |(dataE.addr[OFF_W-1:0] & amask);
  assign mem_op = dataE.valid & (dataE.mem_rd | dataE.mem_wr) & ~clr;
  assign issue  = mem_op & ~misal;
  // Once issued, the request is driven from the latched copy so it stays stable.
  assign cur    = (state == S_IDLE) ? dataE : lat;

  mem_data_align u_align (
    .msize    (cur.msize),
    .msign    (cur.msign),
    .off      (cur.addr[OFF_W-1:0]),
    .wdata    (cur.wdata),
    .line     (resp.data),
    .strobe   (strobe),
    .wdata_al (wdata_al),
    .rdata    (ld_data)
  );

  always_comb begin
    state_nxt = state;
    req_on    = 1'b0;
    done      = 1'b0;
    stallM    = 1'b0;
    dataM     = '0;
    case (state)
      S_IDLE: begin
        dataM.valid    = dataE.valid & ~clr;
        dataM.rdata    = dataE.addr;
        dataM.misalign = mem_op & misal;
        dataM.reg_wr   = dataE.reg_wr;
        dataM.rd       = dataE.rd;
        if (issue) begin
          req_on      = 1'b1;
          stallM      = 1'b1;
          dataM.valid = 1'b0;
          if (resp.addr_ok && resp.data_ok) begin
            stallM = 1'b0;
            done   = 1'b1;
          end else if (resp.addr_ok) state_nxt = S_WAIT;
          else state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        req_on = 1'b1;
        stallM = 1'b1;
        if (resp.addr_ok) begin
          if (resp.data_ok) begin
            stallM    = 1'b0;
            done      = ~clr;
            state_nxt = S_IDLE;
          end else state_nxt = clr ? S_DRAIN : S_WAIT;
        end else if (clr) begin
          // never accepted: drop it and let the flushed slot advance
          stallM    = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        stallM = 1'b1;
        if (resp.data_ok) begin
          stallM    = 1'b0;
          done      = ~clr;
          state_nxt = S_IDLE;
        end else if (clr) state_nxt = S_DRAIN;
      end
      default: begin
        stallM = 1'b1;
        if (resp.data_ok) begin
          stallM    = 1'b0;
          state_nxt = S_IDLE;
        end
      end
    endcase
    if (done) begin
      dataM.valid    = cur.valid;
      dataM.rdata    = (cur.mem_rd && !cur.mem_wr) ? ld_data : cur.addr;
      dataM.misalign = 1'b0;
      dataM.reg_wr   = cur.reg_wr;
      dataM.rd       = cur.rd;
    end
    if (rst) begin
      state_nxt = S_IDLE;
      req_on    = 1'b0;
      stallM    = 1'b0;
      dataM     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && issue) lat <= dataE;
    end
  end

  assign req.valid  = req_on;
  assign req.addr   = req_on ? cur.addr : '0;
  assign req.size   = req_on ? {1'b0, cur.msize} : '0;
  assign req.strobe = (req_on && cur.mem_wr) ? strobe : '0;
  assign req.data   = (req_on && cur.mem_wr) ? wdata_al : '0;

  assign dreq_valid  = req.valid;
  assign dreq_addr   = req.addr[ADDR_W-1:0];
  assign dreq_size   = req.size;
  assign dreq_strobe = req.strobe;
  assign dreq_data   = req.data[DATA_W-1:0];
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions checked against a byte-arithmetic reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic          clk = 1'b0;
  logic          rst, clr;
  execute_data_t dataE;
  memory_data_t  dataM;
  logic          stallM, dreq_valid, dresp_addr_ok, dresp_data_ok;
  logic [63:0]   dreq_addr, dreq_data, dresp_data;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  int            n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .clr(clr), .dataE(dataE), .dataM(dataM), .stallM(stallM),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  function automatic logic [63:0] ref_load(logic [63:0] line, logic [63:0] addr, int sz, logic sgn);
    logic [63:0] v, m;
    int nb;
    nb = 1 << sz;
    v  = line >> (8 * (addr % 8));
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (sgn && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic execute_data_t mk(logic rd_op, logic wr_op, int sz, logic sgn,
                                       logic [63:0] addr, logic [63:0] wd);
    execute_data_t e;
    e = '0;
    e.valid = 1'b1; e.mem_rd = rd_op; e.mem_wr = wr_op; e.msize = msize_t'(sz);
    e.msign = sgn; e.addr = addr; e.wdata = wd; e.reg_wr = rd_op; e.rd = 5'($urandom_range(1, 31));
    return e;
  endfunction

  task automatic cyc(input logic r, input execute_data_t e, input logic c,
                     input logic ao, input logic dk, input logic [63:0] line);
    @(posedge clk); #1;
    rst = r; dataE = e; clr = c; dresp_addr_ok = ao; dresp_data_ok = dk;
    dresp_data = dk ? line : {$urandom(), $urandom()};
    @(negedge clk);
  endtask

  // Runs one instruction until stallM drops; reports what was seen on the bus.
  task automatic run_txn(input execute_data_t e, input int ack_at, input int dat_at,
                         input logic [63:0] line, output dbus_req_t rq, output int req_cyc,
                         output bit stable, output int stall_cyc, output memory_data_t dm,
                         output bit tmo);
    dbus_req_t now;
    rq = '0; req_cyc = 0; stable = 1'b1; stall_cyc = 0; dm = '0; tmo = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, e, 1'b0, k == ack_at, k == dat_at, line);
      now = '{valid: dreq_valid, addr: dreq_addr, size: dreq_size, strobe: dreq_strobe, data: dreq_data};
      if (dreq_valid) begin
        if (req_cyc == 0) rq = now;
        else if (now !== rq) stable = 1'b0;
        req_cyc++;
      end
      if (stallM) stall_cyc++;
      else begin
        dm = dataM; tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    cyc(1'b1, mk(1, 0, 3, 0, 64'h100, 0), 1'b0, 1'b1, 1'b1, 64'h1234);
    n_cmp++;
    if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, stallM, dataM} !== '0) begin
      n_err++; $display("FAIL reset_outputs: dreq_valid=%b stallM=%b dataM=%h, want all zero", dreq_valid, stallM, dataM);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
    n_cmp++;
    if (dataM !== '0 || stallM !== 1'b0 || dreq_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: dataM=%h stallM=%b dreq_valid=%b, want 0/0/0", dataM, stallM, dreq_valid);
    end
  endtask

  task automatic test_load_byte;
    execute_data_t e; dbus_req_t rq; int rc, sc; bit st, tmo; memory_data_t dm;
    e = mk(1, 0, 0, 1, 64'h1003, 0);
    run_txn(e, 0, 0, 64'h0000_0000_8000_0000, rq, rc, st, sc, dm, tmo);
    n_cmp++;
    if (tmo || sc != 0) begin n_err++; $display("FAIL ldrb_stall: stall cycles=%0d tmo=%0d, want 0", sc, tmo); end
    n_cmp++;
    if (rq.strobe !== 8'h00 || rq.size !== 3'd0 || rq.addr !== 64'h1003) begin
      n_err++; $display("FAIL ldrb_req: strobe=%h size=%0d addr=%h, want 00/0/1003", rq.strobe, rq.size, rq.addr);
    end
    n_cmp++;
    if (dm.valid !== 1'b1 || dm.rdata !== 64'hFFFF_FFFF_FFFF_FF80 || dm.rd !== e.rd) begin
      n_err++; $display("FAIL ldrb_data: valid=%b rdata=%h, want 1/ffffffffffffff80", dm.valid, dm.rdata);
    end
  endtask

  task automatic test_store_half_slow;
    execute_data_t e; dbus_req_t rq; int rc, sc; bit st, tmo; memory_data_t dm;
    e = mk(0, 1, 1, 0, 64'h2006, 64'hBEEF);
    run_txn(e, 2, 5, 64'h0, rq, rc, st, sc, dm, tmo);
    n_cmp++;
    if (rq.strobe !== 8'hC0 || rq.data !== (64'hBEEF << 48) || rq.size !== 3'd1) begin
      n_err++; $display("FAIL strh_req: strobe=%h data=%h size=%0d, want c0/beef000000000000/1", rq.strobe, rq.data, rq.size);
    end
    n_cmp++;
    if (rc != 3 || !st) begin n_err++; $display("FAIL strh_hold: req cycles=%0d stable=%0d, want 3/1", rc, st); end
    n_cmp++;
    if (tmo || sc != 5 || dm.valid !== 1'b1) begin
      n_err++; $display("FAIL strh_stall: stall=%0d valid=%b tmo=%0d, want 5/1/0", sc, dm.valid, tmo);
    end
  endtask

  task automatic test_misaligned;
    cyc(1'b0, mk(1, 0, 2, 0, 64'h3002, 0), 1'b0, 1'b1, 1'b1, 64'h55);
    n_cmp++;
    if (dreq_valid !== 1'b0 || stallM !== 1'b0 || dataM.misalign !== 1'b1 || dataM.valid !== 1'b1) begin
      n_err++; $display("FAIL misalign: dreq_valid=%b stallM=%b misalign=%b valid=%b, want 0/0/1/1",
                        dreq_valid, stallM, dataM.misalign, dataM.valid);
    end
  endtask

  // A fresh immediate load proves the FSM is back in IDLE.
  task automatic check_idle_after(input string tag);
    execute_data_t e;
    logic [63:0] line;
    e = mk(1, 0, 3, 0, 64'h7000, 0);
    line = {$urandom(), $urandom()};
    cyc(1'b0, e, 1'b0, 1'b1, 1'b1, line);
    n_cmp++;
    if (stallM !== 1'b0 || dataM.valid !== 1'b1 || dataM.rdata !== line) begin
      n_err++; $display("FAIL %s_idle: stallM=%b valid=%b rdata=%h, want 0/1/%h", tag, stallM, dataM.valid, dataM.rdata, line);
    end
  endtask

  task automatic test_clr_wait;
    execute_data_t e;
    e = mk(1, 0, 3, 0, 64'h4000, 0);
    cyc(1'b0, e, 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, e, 1'b1, 1'b0, 1'b0, 0);
    cyc(1'b0, e, 1'b0, 1'b0, 1'b0, 0);
    n_cmp++;
    if (stallM !== 1'b1 || dataM.valid !== 1'b0 || dreq_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_hold: stallM=%b valid=%b dreq_valid=%b, want 1/0/0", stallM, dataM.valid, dreq_valid);
    end
    cyc(1'b0, e, 1'b0, 1'b0, 1'b1, 64'hDEAD);
    n_cmp++;
    if (stallM !== 1'b0 || dataM.valid !== 1'b0) begin
      n_err++; $display("FAIL drain_done: stallM=%b valid=%b, want 0/0", stallM, dataM.valid);
    end
    check_idle_after("drain");
  endtask

  task automatic test_clr_req;
    execute_data_t e;
    e = mk(1, 0, 2, 0, 64'h5000, 0);
    cyc(1'b0, e, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, e, 1'b1, 1'b0, 1'b0, 0);
    n_cmp++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 64'h5000) begin
      n_err++; $display("FAIL clrreq_hold: dreq_valid=%b addr=%h, want 1/5000", dreq_valid, dreq_addr);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
    n_cmp++;
    if (dreq_valid !== 1'b0 || stallM !== 1'b0) begin
      n_err++; $display("FAIL clrreq_drop: dreq_valid=%b stallM=%b, want 0/0", dreq_valid, stallM);
    end
    check_idle_after("clrreq");
  endtask

  task automatic test_rst_wait;
    execute_data_t e;
    e = mk(1, 0, 3, 0, 64'h6000, 0);
    cyc(1'b0, e, 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, e, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, e, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hBAD);
    n_cmp++;
    if (stallM !== 1'b0 || dreq_valid !== 1'b0 || dataM !== '0) begin
      n_err++; $display("FAIL rst_wait: stallM=%b dreq_valid=%b dataM=%h, want 0/0/0", stallM, dreq_valid, dataM);
    end
    check_idle_after("rst");
  endtask

  task automatic test_random;
    execute_data_t e; dbus_req_t rq; int rc, sc, sz, ack, dat, kind; bit st, tmo, mis;
    memory_data_t dm; logic [63:0] addr, line, wd, exp_data; logic [7:0] exp_strb; int smask;
    for (int n = 0; n < 60; n++) begin
      sz   = $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      addr = {$urandom(), $urandom()};
      mis  = (kind == 9) && (sz != 0);
      if (!mis) addr = addr - (addr % (64'd1 << sz));
      else if (addr % (64'd1 << sz) == 0) addr = addr + 1;
      line = {$urandom(), $urandom()};
      wd   = {$urandom(), $urandom()};
      ack  = $urandom_range(0, 3);
      dat  = ack + $urandom_range(0, 3);
      if (kind == 8) begin
        e = mk(0, 0, sz, 0, addr, wd);
      end else e = mk(kind < 4, kind >= 4, sz, $urandom_range(0, 1), addr, wd);
      run_txn(e, ack, dat, line, rq, rc, st, sc, dm, tmo);
      n_cmp++;
      if (tmo) begin n_err++; $display("FAIL rnd_timeout[%0d]: no completion within bound", n); continue; end
      if (kind == 8 || mis) begin
        n_cmp++;
        if (rc != 0 || sc != 0 || dm.valid !== 1'b1 || dm.misalign !== mis || dm.rd !== e.rd) begin
          n_err++; $display("FAIL rnd_nomem[%0d]: req=%0d stall=%0d valid=%b misalign=%b, want 0/0/1/%0d",
                            n, rc, sc, dm.valid, dm.misalign, mis);
        end
        continue;
      end
      smask    = ((1 << (1 << sz)) - 1) << (addr % 8);
      exp_strb = e.mem_wr ? smask[7:0] : 8'h00;
      exp_data = e.mem_wr ? (wd << (8 * (addr % 8))) : 64'h0;
      n_cmp++;
      if (rq.addr !== addr || rq.size !== 3'(sz) || rq.strobe !== exp_strb || rq.data !== exp_data) begin
        n_err++; $display("FAIL rnd_req[%0d]: addr=%h size=%0d strobe=%h data=%h, want %h/%0d/%h/%h",
                          n, rq.addr, rq.size, rq.strobe, rq.data, addr, sz, exp_strb, exp_data);
      end
      n_cmp++;
      if (rc != ack + 1 || !st || sc != dat) begin
        n_err++; $display("FAIL rnd_timing[%0d]: req=%0d stable=%0d stall=%0d, want %0d/1/%0d", n, rc, st, sc, ack + 1, dat);
      end
      n_cmp++;
      if (dm.valid !== 1'b1 || dm.rd !== e.rd ||
          (e.mem_rd && dm.rdata !== ref_load(line, addr, sz, e.msign))) begin
        n_err++; $display("FAIL rnd_result[%0d]: valid=%b rdata=%h, want 1/%h", n, dm.valid, dm.rdata,
                          ref_load(line, addr, sz, e.msign));
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; dataE = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    test_reset();
    test_load_byte();
    test_store_half_slow();
    test_misaligned();
    test_clr_wait();
    test_clr_req();
    test_rst_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
